// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register: decodes an RV32I instruction into ALU control and operands,
// then holds the result for one cycle behind a valid/ready handshake with flush.
module id_ex_alu_issue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_alu_control,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_branch,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_SLL = 5'b00010;
    localparam logic [4:0] ALU_SLT = 5'b00011, ALU_SLTU = 5'b00100, ALU_XOR = 5'b00101;
    localparam logic [4:0] ALU_SRL = 5'b00110, ALU_SRA = 5'b00111, ALU_OR = 5'b01000;
    localparam logic [4:0] ALU_AND = 5'b01001, ALU_PASSB = 5'b01010, ALU_EQ = 5'b01011;
    localparam logic [4:0] ALU_NE = 5'b01100, ALU_LT = 5'b01101, ALU_GE = 5'b01110;
    localparam logic [4:0] ALU_LTU = 5'b01111, ALU_GEU = 5'b10000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]      alu_control;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_branch;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } payload_t;

    // Base ALU op for funct3 when funct7 selects the primary encoding
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_u_s, shamt_s, link_off_s;
    logic [4:0]      raw_ctrl_s;
    logic [XLEN-1:0] raw_a_s, raw_b_s;
    logic            raw_rw_s, raw_br_s, raw_mr_s, raw_mw_s, dec_ill_s;
    logic            load_s;
    logic            unused_s;
    payload_t        dec_s;
    payload_t        payload_d, payload_q;
    logic            valid_d, valid_q;

    assign opcode_s   = in_instr[6:0];
    assign funct3_s   = in_instr[14:12];
    assign funct7_s   = in_instr[31:25];
    assign imm_i_s    = XLEN'($signed(in_instr[31:20]));
    assign imm_s_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_u_s    = XLEN'($signed({in_instr[31:12], 12'h000}));
    assign shamt_s    = XLEN'(in_instr[24:20]);
    assign link_off_s = XLEN'(3'd4);
    assign unused_s   = ^in_instr[19:15];

    // Opcode/funct decode into raw control and operand selection
    always_comb begin
        raw_ctrl_s = ALU_ADD;
        raw_a_s    = {XLEN{1'b0}};
        raw_b_s    = {XLEN{1'b0}};
        raw_rw_s   = 1'b0;
        raw_br_s   = 1'b0;
        raw_mr_s   = 1'b0;
        raw_mw_s   = 1'b0;
        dec_ill_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                raw_a_s  = in_rs1_data;
                raw_b_s  = in_rs2_data;
                raw_rw_s = 1'b1;
                if (funct7_s == F7_BASE) begin
                    raw_ctrl_s = alu_base(funct3_s);
                end else if (funct7_s == F7_ALT && funct3_s == 3'b000) begin
                    raw_ctrl_s = ALU_SUB;
                end else if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
                    raw_ctrl_s = ALU_SRA;
                end else begin
                    dec_ill_s = 1'b1;
                end
            end
            OPC_OPIMM: begin
                raw_a_s    = in_rs1_data;
                raw_rw_s   = 1'b1;
                raw_ctrl_s = alu_base(funct3_s);
                case (funct3_s)
                    3'b001: begin
                        raw_b_s   = shamt_s;
                        dec_ill_s = (funct7_s != F7_BASE);
                    end
                    3'b101: begin
                        raw_b_s    = shamt_s;
                        raw_ctrl_s = (funct7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_ill_s  = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                    end
                    default: raw_b_s = imm_i_s;
                endcase
            end
            OPC_LUI: begin
                raw_ctrl_s = ALU_PASSB;
                raw_b_s    = imm_u_s;
                raw_rw_s   = 1'b1;
            end
            OPC_AUIPC: begin
                raw_a_s  = in_pc;
                raw_b_s  = imm_u_s;
                raw_rw_s = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                raw_a_s  = in_pc;
                raw_b_s  = link_off_s;
                raw_rw_s = 1'b1;
            end
            OPC_BRANCH: begin
                raw_a_s  = in_rs1_data;
                raw_b_s  = in_rs2_data;
                raw_br_s = 1'b1;
                case (funct3_s)
                    3'b000:  raw_ctrl_s = ALU_EQ;
                    3'b001:  raw_ctrl_s = ALU_NE;
                    3'b100:  raw_ctrl_s = ALU_LT;
                    3'b101:  raw_ctrl_s = ALU_GE;
                    3'b110:  raw_ctrl_s = ALU_LTU;
                    3'b111:  raw_ctrl_s = ALU_GEU;
                    default: dec_ill_s  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                raw_a_s  = in_rs1_data;
                raw_b_s  = imm_i_s;
                raw_mr_s = 1'b1;
                raw_rw_s = 1'b1;
            end
            OPC_STORE: begin
                raw_a_s  = in_rs1_data;
                raw_b_s  = imm_s_s;
                raw_mw_s = 1'b1;
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    // Illegal instructions travel as inert bubbles; rd=x0 never writes
    assign dec_s.alu_control = dec_ill_s ? ALU_ADD : raw_ctrl_s;
    assign dec_s.a           = dec_ill_s ? {XLEN{1'b0}} : raw_a_s;
    assign dec_s.b           = dec_ill_s ? {XLEN{1'b0}} : raw_b_s;
    assign dec_s.store_data  = in_rs2_data;
    assign dec_s.pc          = in_pc;
    assign dec_s.rd          = in_instr[11:7];
    assign dec_s.reg_write   = raw_rw_s & ~dec_ill_s & (in_instr[11:7] != 5'd0);
    assign dec_s.is_branch   = raw_br_s & ~dec_ill_s;
    assign dec_s.mem_read    = raw_mr_s & ~dec_ill_s;
    assign dec_s.mem_write   = raw_mw_s & ~dec_ill_s;
    assign dec_s.illegal     = dec_ill_s;

    assign in_ready = ~valid_q | out_ready;
    assign load_s   = in_valid & in_ready & ~flush;

    // Next-state for the valid bit and payload; flush beats load and stall
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (load_s) begin
            payload_d = dec_s;
        end else begin
            payload_d = payload_q;
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            payload_q    <= '0;
            payload_q.pc <= RESET_PC;
        end else begin
            valid_q      <= valid_d;
            payload_q    <= payload_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_alu_control = payload_q.alu_control;
    assign out_a           = payload_q.a;
    assign out_b           = payload_q.b;
    assign out_store_data  = payload_q.store_data;
    assign out_pc          = payload_q.pc;
    assign out_rd          = payload_q.rd;
    assign out_reg_write   = payload_q.reg_write;
    assign out_is_branch   = payload_q.is_branch;
    assign out_mem_read    = payload_q.mem_read;
    assign out_mem_write   = payload_q.mem_write;
    assign out_illegal     = payload_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed program snippets plus random traffic,
// checked against an opcode-table reference decoder.
module tb_id_ex_alu_issue;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic [4:0]  out_alu_control, out_rd;
    logic [31:0] out_a, out_b, out_store_data, out_pc;
    logic        out_reg_write, out_is_branch, out_mem_read, out_mem_write, out_illegal;

    id_ex_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
        .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data), .out_pc(out_pc),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned ctrl;
        logic [31:0] a, b, sd, pc;
        logic [4:0]  rd;
        logic        rw, br, mr, mw, ill;
    } exp_t;

    exp_t sbq[$];
    logic exp_valid = 1'b0;
    logic mon_en    = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the ISA tables
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        int base[8];
        int brc[8];
        int f3, f7, code;
        bit legal;
        logic [31:0] immi, imms, immu;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        brc  = '{11, 12, -1, -1, 13, 14, 15, 16};
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immu = {ins[31:12], 12'h000};
        e = '{ctrl: 0, a: 32'd0, b: 32'd0, sd: rs2, pc: pc, rd: ins[11:7],
              rw: 1'b0, br: 1'b0, mr: 1'b0, mw: 1'b0, ill: 1'b0};
        legal = 1'b1;
        code = 0;
        case (ins[6:0])
            7'h33: begin
                e.a = rs1; e.b = rs2; e.rw = 1'b1;
                if (f7 == 0) code = base[f3];
                else if (f7 == 32 && (f3 == 0 || f3 == 5)) code = base[f3] + 1;
                else legal = 1'b0;
            end
            7'h13: begin
                e.a = rs1; e.rw = 1'b1; code = base[f3];
                if (f3 == 1 || f3 == 5) begin
                    e.b = {27'd0, ins[24:20]};
                    if (f7 == 0) code = base[f3];
                    else if (f3 == 5 && f7 == 32) code = base[f3] + 1;
                    else legal = 1'b0;
                end else e.b = immi;
            end
            7'h37: begin code = 10; e.b = immu; e.rw = 1'b1; end
            7'h17: begin e.a = pc; e.b = immu; e.rw = 1'b1; end
            7'h6f, 7'h67: begin e.a = pc; e.b = 32'd4; e.rw = 1'b1; end
            7'h63: begin
                e.a = rs1; e.b = rs2; e.br = 1'b1; code = brc[f3];
                if (code < 0) legal = 1'b0;
            end
            7'h03: begin e.a = rs1; e.b = immi; e.mr = 1'b1; e.rw = 1'b1; end
            7'h23: begin e.a = rs1; e.b = imms; e.mw = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            code = 0; e.rw = 1'b0; e.br = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        e.ctrl = (code < 0) ? 0 : code;
        return e;
    endfunction

    // Monitor: compares the held payload with the scoreboard head every cycle it is valid
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            exp_t e;
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_valid) || out_ready});
            if (exp_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sbq[0];
                    chk("alu_control", {27'd0, out_alu_control}, e.ctrl);
                    chk("pc", out_pc, e.pc);
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                    chk("is_branch", {31'd0, out_is_branch}, {31'd0, e.br});
                    chk("mem_read", {31'd0, out_mem_read}, {31'd0, e.mr});
                    chk("mem_write", {31'd0, out_mem_write}, {31'd0, e.mw});
                    chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    if (!e.ill) begin
                        chk("a", out_a, e.a);
                        chk("b", out_b, e.b);
                    end
                    if (e.mw) chk("store_data", out_store_data, e.sd);
                    if (out_ready || flush) void'(sbq.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; called just after a rising edge
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic ordy, input logic fl);
        logic acc, nv;
        in_valid = iv; in_instr = ins; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        acc = iv && ((!exp_valid) || ordy) && !fl;
        if (acc) sbq.push_back(ref_decode(ins, pc, rs1, rs2));
        nv = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : exp_valid));
        @(posedge clk);
        exp_valid = nv;
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0000_0013, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_pc"}, out_pc, RST_PC);
        chk({tag, "_ctrl_a_b"}, {27'd0, out_alu_control} | out_a | out_b | out_store_data, 32'd0);
        chk({tag, "_flags"}, {26'd0, out_rd, out_reg_write, out_is_branch, out_mem_read,
            out_mem_write, out_illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc[10];
        int k;
        opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h00};
        ins = $urandom;
        k = $urandom_range(0, 9);
        ins[6:0] = (k == 9) ? 7'($urandom) : opc[k];
        k = $urandom_range(0, 9);
        ins[31:25] = (k < 6) ? 7'h00 : ((k < 8) ? 7'h20 : 7'($urandom));
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        drive(1'b1, 32'hFF30_0093, 32'h0000_0100, 32'd0, 32'd7, 1'b1, 1'b0);       // addi x1,x0,-13
        drive(1'b1, 32'h4020_81B3, 32'h0000_0104, 32'd15, 32'd10, 1'b1, 1'b0);     // sub x3,x1,x2
        drive(1'b1, 32'h4040_D213, 32'h0000_0108, 32'hB38F_0F83, 32'd0, 1'b1, 1'b0); // srai x4,x1,4
        drive(1'b1, 32'h0020_D463, 32'h0000_010C, 32'd3, 32'd9, 1'b1, 1'b0);      // bge x1,x2
        repeat (3) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        drive(1'b1, 32'hAAAA_A2B7, 32'h0000_0200, 32'd1, 32'd2, 1'b0, 1'b0);      // lui x5
        drive(1'b1, 32'hFF30_0093, 32'h0000_0204, 32'd0, 32'd0, 1'b0, 1'b1);      // flushed
        idle(1'b1);
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0300, 32'd5, 32'd6, 1'b1, 1'b0);      // illegal
        drive(1'b1, 32'hAAAA_A037, 32'h0000_0304, 32'd0, 32'd0, 1'b1, 1'b0);      // lui x0
        drive(1'b1, 32'h0011_2423, 32'h0000_0308, 32'h1000, 32'hCAFE_F00D, 1'b1, 1'b0); // sw
        idle(1'b1);

        drive(1'b1, 32'h0040_A283, 32'h0000_0400, 32'h2000, 32'd0, 1'b0, 1'b0);  // lw, then stall
        idle(1'b0);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
        sbq.delete();
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("midstall_reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
